// File: rtl/subtree_rr_scheduler_pkg.sv
// subtree_sched_pkg: shared state type, default sizes and rotating-priority helper
package subtree_sched_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    localparam int N_REQ_DEF = 5;
    localparam int MAX_HOLD_DEF = 16;
    function automatic int next_rr(input int ptr, input logic [31:0] req, input int n = N_REQ_DEF);
        int r = ptr;
        int j;
        for (int i = n - 1; i >= 0; i--) begin
            j = (ptr + i) % n;
            if (req[j[4:0]]) r = j;
        end
        return r;
    endfunction
endpackage

// File: rtl/subtree_rr_scheduler_if.sv
// subtree_rr_scheduler_if: request/grant bundle between children and the scheduler
interface subtree_rr_scheduler_if #(
    parameter int N_REQ = subtree_sched_pkg::N_REQ_DEF,
    parameter int ID_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] done_i;
    logic [N_REQ-1:0] gnt_o;
    logic gnt_valid_o;
    logic [ID_W-1:0] gnt_id_o;
    logic timeout_o;
    logic busy_o;
    modport master (output req_i, done_i, input gnt_o, gnt_valid_o, gnt_id_o, timeout_o, busy_o);
    modport slave (input req_i, done_i, output gnt_o, gnt_valid_o, gnt_id_o, timeout_o, busy_o);
endinterface

// File: rtl/subtree_rr_scheduler_rr_pick.sv
// rr_pick: combinational rotating-priority encoder, first set bit at or after ptr
module rr_pick #(
    parameter int N_REQ = subtree_sched_pkg::N_REQ_DEF,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    import subtree_sched_pkg::*;
    always_comb begin
        idx = ID_W'(next_rr(int'(ptr), 32'(req), N_REQ));
        any = |req;
    end
endmodule

// File: rtl/subtree_rr_scheduler.sv
// subtree_rr_scheduler: round-robin owner of one shared slot with hold timeout
module subtree_rr_scheduler #(
    parameter int N_REQ = subtree_sched_pkg::N_REQ_DEF,
    parameter int MAX_HOLD = subtree_sched_pkg::MAX_HOLD_DEF,
    parameter int ID_W = $clog2(N_REQ)
) (
    input logic clk,
    input logic rst,
    subtree_rr_scheduler_if.slave bus
);
    import subtree_sched_pkg::*;
    localparam int CW = $clog2(MAX_HOLD);
    state_t state, state_d;
    logic [ID_W-1:0] owner, ptr, pick;
    logic [CW-1:0] cnt;
    logic any, rel, forced, timeout;
    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (.req(bus.req_i), .ptr(ptr), .idx(pick), .any(any));
    // done beats withdrawal beats timeout, so forced only when the owner is still busy
    always_comb begin
        forced = cnt == CW'(MAX_HOLD - 1) && bus.req_i[owner] && !bus.done_i[owner];
        rel = bus.done_i[owner] || !bus.req_i[owner] || forced;
        state_d = state == IDLE ? (any ? GRANT : IDLE) : state == GRANT ? (rel ? RELEASE : GRANT) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr <= '0;
            cnt <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_d;
            timeout <= state == GRANT && forced;
            cnt <= state == GRANT && !rel ? cnt + 1'b1 : '0;
            if (state == IDLE && any) owner <= pick;
            if (state == RELEASE) ptr <= owner == ID_W'(N_REQ - 1) ? '0 : owner + 1'b1;
        end
    end
    assign bus.gnt_o = state == GRANT ? N_REQ'(1) << owner : '0;
    assign bus.gnt_valid_o = state == GRANT;
    assign bus.gnt_id_o = owner;
    assign bus.timeout_o = timeout;
    assign bus.busy_o = state != IDLE;
endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// tb_subtree_rr_scheduler: directed and random stimulus against a behavioural scheduler model
module tb_subtree_rr_scheduler;
    localparam int N = 5;
    localparam int H = 16;
    typedef struct packed {
        logic [N-1:0] gnt;
        logic v;
        logic [2:0] id;
        logic t;
        logic b;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    subtree_rr_scheduler_if #(.N_REQ(N)) bus ();
    subtree_rr_scheduler #(.N_REQ(N), .MAX_HOLD(H)) dut (.clk(clk), .rst(rst), .bus(bus));
    exp_t q[$];
    int vectors = 0;
    int errors = 0;
    // model: phase 0 idle, 1 granted, 2 dead cycle
    int m_ph, m_own, m_age, m_ptr;
    bit m_to;
    function automatic void m_reset();
        m_ph = 0; m_own = 0; m_age = 0; m_ptr = 0; m_to = 0;
    endfunction
    function automatic void m_step(input logic [N-1:0] r, input logic [N-1:0] d);
        m_to = 0;
        if (m_ph == 0) begin
            if (r != 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (((r >> ((m_ptr + k) % N)) & 5'd1) != 0) m_own = (m_ptr + k) % N;
                m_ph = 1;
                m_age = 0;
            end
        end else if (m_ph == 1) begin
            if ((((d | ~r) >> m_own) & 5'd1) != 0) m_ph = 2;
            else if (m_age == H - 1) begin
                m_ph = 2;
                m_to = 1;
            end else m_age++;
        end else begin
            m_ptr = (m_own + 1) % N;
            m_ph = 0;
        end
    endfunction
    function automatic exp_t m_out();
        exp_t e;
        e.gnt = m_ph == 1 ? N'(1 << m_own) : '0;
        e.v = m_ph == 1;
        e.id = 3'(m_own);
        e.t = m_to;
        e.b = m_ph != 0;
        return e;
    endfunction
    function automatic exp_t sample();
        return {bus.gnt_o, bus.gnt_valid_o, bus.gnt_id_o, bus.timeout_o, bus.busy_o};
    endfunction
    function automatic void check(input string nm, input exp_t got, input exp_t exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got gnt=%b v=%b id=%0d to=%b busy=%b, expected gnt=%b v=%b id=%0d to=%b busy=%b",
                     nm, $time, got.gnt, got.v, got.id, got.t, got.b, exp.gnt, exp.v, exp.id, exp.t, exp.b);
        end
    endfunction
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input bit rs);
        @(negedge clk);
        rst = rs;
        bus.req_i = r;
        bus.done_i = d;
        if (rs) m_reset();
        else m_step(r, d);
        q.push_back(m_out());
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) check("cycle", sample(), q.pop_front());
    end
    initial begin
        logic [N-1:0] r;
        bus.req_i = '0;
        bus.done_i = '0;
        m_reset();
        cyc('0, '0, 1);
        cyc('0, '0, 1);
        for (int i = 0; i < 5; i++) cyc(5'b00100, (m_ph == 1 && m_age == 3) ? 5'b00100 : 5'b0, 0);
        for (int i = 0; i < 4; i++) cyc('0, '0, 0);
        cyc('0, '0, 1);
        for (int i = 0; i < 20; i++) cyc(5'h1f, m_ph == 1 ? N'(1 << m_own) : 5'b0, 0);
        for (int i = 0; i < 40; i++) cyc(5'b01000, '0, 0);
        for (int i = 0; i < 40; i++) cyc(5'b01000, (m_ph == 1 && m_age == H - 1) ? 5'b01000 : 5'b0, 0);
        for (int i = 0; i < 3; i++) cyc('0, '0, 0);
        for (int i = 0; i < 6; i++) cyc(5'b00010, 5'b00001, 0);
        for (int i = 0; i < 4; i++) cyc('0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(5'h1f, '0, 0);
        r = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) r = N'($urandom);
            cyc(r, $urandom_range(0, 15) == 0 ? N'($urandom) : 5'b0, 0);
        end
        cyc('0, '0, 1);
        for (int i = 0; i < 3; i++) cyc(5'b10000, '0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", sample(), '0);
        cyc(5'h1f, '0, 1);
        for (int i = 0; i < 6; i++) cyc(5'h1f, '0, 0);
        cyc('0, '0, 0);
        @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
